// File: rtl/mips_tb_pkg.sv
// ----------------------------------------------------------------------------
// mips_tb_pkg
// Shared types for the MIPS store-sequence checker.
//   memwrite_t  : encoding of the data-memory write strobe/size.
//   chk_state_t : checker FSM states (RUN is live, PASS/FAIL are terminal).
//   fail_code_t : reason reported on the fail_code output.
//   size_mask() : data compare mask for a given store size.
// ----------------------------------------------------------------------------
package mips_tb_pkg;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_BYTE = 2'b01,
        MW_HALF = 2'b10,
        MW_WORD = 2'b11
    } memwrite_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } chk_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ADDR    = 2'b01,
        FC_DATA    = 2'b10,
        FC_TIMEOUT = 2'b11
    } fail_code_t;

    // Store data is right-aligned, so only the low bytes of the bus carry
    // meaning for sub-word stores.
    function automatic logic [31:0] size_mask(input memwrite_t mw);
        logic [31:0] mask;
        case (mw)
            MW_BYTE: mask = 32'h0000_00FF;
            MW_HALF: mask = 32'h0000_FFFF;
            MW_WORD: mask = 32'hFFFF_FFFF;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_match.sv
// ----------------------------------------------------------------------------
// store_match
// Purely combinational compare of the live store bus against one expected
// store entry.
//   exp_addr/exp_data/exp_size : the expected entry.
//   memwrite/dataadr/writedata : the live data-memory write port.
//   addr_hit : address equal.
//   data_hit : size equal and data equal under the size mask.
// ----------------------------------------------------------------------------
module store_match
    import mips_tb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [1:0]        exp_size,
    input  logic [1:0]        memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              addr_hit,
    output logic              data_hit
);

    logic [DATA_W-1:0] mask;
    logic              size_eq;

    always_comb begin
        mask     = size_mask(memwrite_t'(memwrite));
        size_eq  = (memwrite == exp_size);
        addr_hit = (dataadr == exp_addr);
        // Size must match first, so masking with the live size is the same as
        // masking with the expected size whenever data_hit can be true.
        data_hit = size_eq && (((writedata ^ exp_data) & mask) == '0);
    end

endmodule

// File: rtl/mips_store_checker.sv
// ----------------------------------------------------------------------------
// mips_store_checker
// Cycle-accurate monitor of the MIPS data-memory write port. Each store is
// compared, in order, against NUM_EXP expected stores. Reports PASS once all
// entries matched, or FAIL with a cause code and the entry index being
// waited on. A cycle counter forces a timeout fail if the program hangs.
// Ports:
//   clk, reset_n (async, active-low)
//   memwrite/dataadr/writedata : observed store bus
//   exp_addr/exp_data/exp_size : packed expected entries, entry i in slice i
//   done, pass, fail_code, fail_idx, match_count : registered status
// ----------------------------------------------------------------------------
module mips_store_checker
    import mips_tb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_EXP = 4,
    parameter int TIMEOUT = 4096,
    parameter int STRICT  = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [1:0]                     memwrite,
    input  logic [ADDR_W-1:0]              dataadr,
    input  logic [DATA_W-1:0]              writedata,
    input  logic [NUM_EXP*ADDR_W-1:0]      exp_addr,
    input  logic [NUM_EXP*DATA_W-1:0]      exp_data,
    input  logic [NUM_EXP*2-1:0]           exp_size,
    output logic                           done,
    output logic                           pass,
    output logic [1:0]                     fail_code,
    output logic [$clog2(NUM_EXP+1)-1:0]   fail_idx,
    output logic [$clog2(NUM_EXP+1)-1:0]   match_count
);

    localparam int CW  = $clog2(NUM_EXP + 1);
    // Table index width; the table is padded to a power of two so any value
    // of the index selects a defined entry.
    localparam int IW  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
    localparam int TAB = 1 << IW;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_EXP - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    chk_state_t    state_q,       state_d;
    fail_code_t    fail_code_q,   fail_code_d;
    logic [CW-1:0] fail_idx_q,    fail_idx_d;
    logic [CW-1:0] match_count_q, match_count_d;
    logic [TW-1:0] cnt_q,         cnt_d;

    logic [ADDR_W-1:0] addr_tab [TAB];
    logic [DATA_W-1:0] data_tab [TAB];
    logic [1:0]        size_tab [TAB];

    logic [IW-1:0] sel_idx;
    logic          addr_hit;
    logic          data_hit;
    logic          store_vld;
    logic          timeout_hit;

    // Unpack the flat expected-entry buses into tables.
    generate
        for (genvar gi = 0; gi < TAB; gi++) begin : g_tab
            if (gi < NUM_EXP) begin : g_used
                assign addr_tab[gi] = exp_addr[gi*ADDR_W +: ADDR_W];
                assign data_tab[gi] = exp_data[gi*DATA_W +: DATA_W];
                assign size_tab[gi] = exp_size[gi*2 +: 2];
            end else begin : g_pad
                assign addr_tab[gi] = '0;
                assign data_tab[gi] = '0;
                assign size_tab[gi] = '0;
            end
        end
    endgenerate

    // While in RUN, match_count is always below NUM_EXP, so its low bits
    // address a real entry.
    assign sel_idx = match_count_q[IW-1:0];

    store_match #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store_match (
        .exp_addr  (addr_tab[sel_idx]),
        .exp_data  (data_tab[sel_idx]),
        .exp_size  (size_tab[sel_idx]),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .addr_hit  (addr_hit),
        .data_hit  (data_hit)
    );

    assign store_vld   = (memwrite_t'(memwrite) != MW_NONE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TOUT_LAST);

    always_comb begin
        state_d       = state_q;
        fail_code_d   = fail_code_q;
        fail_idx_d    = fail_idx_q;
        match_count_d = match_count_q;
        cnt_d         = cnt_q;

        if (state_q == RUN) begin
            if (store_vld) begin
                if (!addr_hit) begin
                    state_d     = FAIL;
                    fail_code_d = FC_ADDR;
                    fail_idx_d  = match_count_q;
                end else if (data_hit) begin
                    match_count_d = match_count_q + 1'b1;
                    if (match_count_q == LAST_IDX) begin
                        state_d = PASS;
                    end
                end else if (STRICT != 0) begin
                    state_d     = FAIL;
                    fail_code_d = FC_DATA;
                    fail_idx_d  = match_count_q;
                end
            end

            // A store that ends the run on this edge outranks the timeout;
            // anything else (partial match, ignored store, idle) does not.
            if ((state_d == RUN) && timeout_hit) begin
                state_d     = FAIL;
                fail_code_d = FC_TIMEOUT;
                fail_idx_d  = match_count_q;
            end

            if ((state_d == RUN) && (TIMEOUT != 0)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            fail_code_q   <= FC_NONE;
            fail_idx_q    <= '0;
            match_count_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
            fail_idx_q    <= fail_idx_d;
            match_count_q <= match_count_d;
            cnt_q         <= cnt_d;
        end
    end

    assign done        = (state_q != RUN);
    assign pass        = (state_q == PASS);
    assign fail_code   = fail_code_q;
    assign fail_idx    = fail_idx_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_mips_store_checker.sv
// ----------------------------------------------------------------------------
// tb_mips_store_checker
// Directed bench for mips_store_checker. Three instances share the store bus,
// each with its own reset so only the one under test is active:
//   dut1 : NUM_EXP=1, STRICT=0, timeout disabled
//   dut2 : NUM_EXP=2, STRICT=0, TIMEOUT=4096
//   dut3 : NUM_EXP=1, STRICT=1, TIMEOUT=16
// ----------------------------------------------------------------------------
module tb_mips_store_checker;

    logic        clk = 1'b0;
    logic        rst1_n = 1'b1;
    logic        rst2_n = 1'b1;
    logic        rst3_n = 1'b1;
    logic [1:0]  memwrite = 2'b00;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;

    // dut1: entry {80, 0xFFFFFFFF, word}; reprogrammed by the byte test
    logic [31:0] exp1_addr = 32'd80;
    logic [31:0] exp1_data = 32'hFFFF_FFFF;
    logic [1:0]  exp1_size = 2'b11;
    // dut2: entry0 {80, 0xFFFFFFFF, word}, entry1 {84, 0x1234, half}
    logic [63:0] exp2_addr = {32'd84, 32'd80};
    logic [63:0] exp2_data = {32'h0000_1234, 32'hFFFF_FFFF};
    logic [3:0]  exp2_size = {2'b10, 2'b11};
    // dut3: entry {80, 0xFFFFFFFF, word}
    logic [31:0] exp3_addr = 32'd80;
    logic [31:0] exp3_data = 32'hFFFF_FFFF;
    logic [1:0]  exp3_size = 2'b11;

    logic       d1_done, d1_pass;
    logic [1:0] d1_fc;
    logic [0:0] d1_fidx, d1_mc;
    logic       d2_done, d2_pass;
    logic [1:0] d2_fc;
    logic [1:0] d2_fidx, d2_mc;
    logic       d3_done, d3_pass;
    logic [1:0] d3_fc;
    logic [0:0] d3_fidx, d3_mc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_store_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(1), .TIMEOUT(0), .STRICT(0)) dut1 (
        .clk(clk), .reset_n(rst1_n), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_addr(exp1_addr), .exp_data(exp1_data), .exp_size(exp1_size),
        .done(d1_done), .pass(d1_pass), .fail_code(d1_fc), .fail_idx(d1_fidx), .match_count(d1_mc)
    );

    mips_store_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .TIMEOUT(4096), .STRICT(0)) dut2 (
        .clk(clk), .reset_n(rst2_n), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_addr(exp2_addr), .exp_data(exp2_data), .exp_size(exp2_size),
        .done(d2_done), .pass(d2_pass), .fail_code(d2_fc), .fail_idx(d2_fidx), .match_count(d2_mc)
    );

    mips_store_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(1), .TIMEOUT(16), .STRICT(1)) dut3 (
        .clk(clk), .reset_n(rst3_n), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_addr(exp3_addr), .exp_data(exp3_data), .exp_size(exp3_size),
        .done(d3_done), .pass(d3_pass), .fail_code(d3_fc), .fail_idx(d3_fidx), .match_count(d3_mc)
    );

    // One store cycle: drive at the falling edge, sample 1ns after the rising edge.
    task automatic drive(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        @(posedge clk);
        #1;
        $display("store mw=%b adr=%0d data=%h", mw, a, d);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        memwrite  = 2'b00;
        dataadr   = 32'd0;
        writedata = 32'd0;
    endtask

    task automatic test_reset();
        #2;
        rst1_n = 1'b0; rst2_n = 1'b0; rst3_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (d1_done !== 1'b0 || d1_pass !== 1'b0) begin $display("FAIL reset_d1_status got done=%b pass=%b expected 0 0", d1_done, d1_pass); n_fail++; end
        n_checks++; if (d2_fc !== 2'b00 || d2_fidx !== 2'd0 || d2_mc !== 2'd0) begin $display("FAIL reset_d2_regs got fc=%b fidx=%0d mc=%0d expected 0 0 0", d2_fc, d2_fidx, d2_mc); n_fail++; end
        n_checks++; if (d3_done !== 1'b0 || d3_fc !== 2'b00 || d3_mc !== 1'b0) begin $display("FAIL reset_d3_regs got done=%b fc=%b mc=%0d expected 0 0 0", d3_done, d3_fc, d3_mc); n_fail++; end
    endtask

    task automatic test_word_pass();
        @(negedge clk); rst1_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (d1_done !== 1'b0) begin $display("FAIL word_idle_done got %b expected 0", d1_done); n_fail++; end
        drive(2'b11, 32'd80, 32'hFFFF_FFFF);  // rising edge 5 after release
        n_checks++; if (d1_pass !== 1'b1 || d1_done !== 1'b1) begin $display("FAIL word_pass got pass=%b done=%b expected 1 1", d1_pass, d1_done); n_fail++; end
        n_checks++; if (d1_mc !== 1'b1 || d1_fc !== 2'b00) begin $display("FAIL word_pass_regs got mc=%0d fc=%b expected 1 00", d1_mc, d1_fc); n_fail++; end
        // Terminal: a bad store afterwards must not disturb anything.
        drive(2'b11, 32'd44, 32'h0);
        n_checks++; if (d1_pass !== 1'b1 || d1_fc !== 2'b00) begin $display("FAIL word_hold got pass=%b fc=%b expected 1 00", d1_pass, d1_fc); n_fail++; end
        bus_idle();
    endtask

    task automatic test_byte_mask();
        rst1_n = 1'b0;
        exp1_data = 32'h0000_00FF;
        exp1_size = 2'b01;
        @(negedge clk); rst1_n = 1'b1;
        // Correct address, wrong size: ignored when not strict.
        drive(2'b11, 32'd80, 32'h0000_00FF);
        n_checks++; if (d1_done !== 1'b0 || d1_mc !== 1'b0) begin $display("FAIL byte_size_ignored got done=%b mc=%0d expected 0 0", d1_done, d1_mc); n_fail++; end
        drive(2'b01, 32'd80, 32'h1234_56FF);
        n_checks++; if (d1_pass !== 1'b1 || d1_mc !== 1'b1) begin $display("FAIL byte_mask_pass got pass=%b mc=%0d expected 1 1", d1_pass, d1_mc); n_fail++; end
        bus_idle();
        rst1_n = 1'b0;
    endtask

    task automatic test_addr_miss();
        @(negedge clk); rst2_n = 1'b1;
        drive(2'b11, 32'd84, 32'hFFFF_FFFF);
        n_checks++; if (d2_done !== 1'b1 || d2_pass !== 1'b0 || d2_fc !== 2'b01) begin $display("FAIL addr_miss got done=%b pass=%b fc=%b expected 1 0 01", d2_done, d2_pass, d2_fc); n_fail++; end
        n_checks++; if (d2_fidx !== 2'd0 || d2_mc !== 2'd0) begin $display("FAIL addr_miss_idx got fidx=%0d mc=%0d expected 0 0", d2_fidx, d2_mc); n_fail++; end
        bus_idle();
        rst2_n = 1'b0;
    endtask

    task automatic test_data_nonstrict();
        @(negedge clk); rst2_n = 1'b1;
        drive(2'b11, 32'd80, 32'h0000_0000);
        n_checks++; if (d2_done !== 1'b0 || d2_mc !== 2'd0 || d2_fc !== 2'b00) begin $display("FAIL nonstrict_ignore got done=%b mc=%0d fc=%b expected 0 0 00", d2_done, d2_mc, d2_fc); n_fail++; end
        drive(2'b11, 32'd80, 32'hFFFF_FFFF);
        n_checks++; if (d2_done !== 1'b0 || d2_mc !== 2'd1) begin $display("FAIL nonstrict_first got done=%b mc=%0d expected 0 1", d2_done, d2_mc); n_fail++; end
        // Half store: upper half of writedata is don't-care.
        drive(2'b10, 32'd84, 32'hDEAD_1234);
        n_checks++; if (d2_pass !== 1'b1 || d2_mc !== 2'd2) begin $display("FAIL nonstrict_half_pass got pass=%b mc=%0d expected 1 2", d2_pass, d2_mc); n_fail++; end
        bus_idle();
        rst2_n = 1'b0;
    endtask

    task automatic test_strict();
        @(negedge clk); rst3_n = 1'b1;
        drive(2'b11, 32'd80, 32'h0000_0000);
        n_checks++; if (d3_done !== 1'b1 || d3_pass !== 1'b0 || d3_fc !== 2'b10 || d3_fidx !== 1'b0) begin $display("FAIL strict_data got done=%b pass=%b fc=%b fidx=%0d expected 1 0 10 0", d3_done, d3_pass, d3_fc, d3_fidx); n_fail++; end
        bus_idle();
        rst3_n = 1'b0;
    endtask

    task automatic test_timeout();
        // Plain timeout: fail on the 16th rising edge after release.
        @(negedge clk); rst3_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        n_checks++; if (d3_done !== 1'b0) begin $display("FAIL timeout_early got done=%b expected 0 after edge 15", d3_done); n_fail++; end
        @(posedge clk); #1;
        n_checks++; if (d3_done !== 1'b1 || d3_fc !== 2'b11 || d3_fidx !== 1'b0) begin $display("FAIL timeout_fire got done=%b fc=%b fidx=%0d expected 1 11 0", d3_done, d3_fc, d3_fidx); n_fail++; end
        rst3_n = 1'b0;

        // Matching store on the timeout edge wins.
        @(negedge clk); rst3_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        drive(2'b11, 32'd80, 32'hFFFF_FFFF);
        n_checks++; if (d3_pass !== 1'b1 || d3_fc !== 2'b00) begin $display("FAIL timeout_match_wins got pass=%b fc=%b expected 1 00", d3_pass, d3_fc); n_fail++; end
        bus_idle();
        rst3_n = 1'b0;

        // Address miss on the timeout edge reports the address cause.
        @(negedge clk); rst3_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        drive(2'b11, 32'd88, 32'hFFFF_FFFF);
        n_checks++; if (d3_done !== 1'b1 || d3_fc !== 2'b01) begin $display("FAIL timeout_addr_wins got done=%b fc=%b expected 1 01", d3_done, d3_fc); n_fail++; end
        bus_idle();
        rst3_n = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); rst2_n = 1'b1;
        drive(2'b11, 32'd80, 32'hFFFF_FFFF);
        n_checks++; if (d2_mc !== 2'd1) begin $display("FAIL midrst_pre got mc=%0d expected 1", d2_mc); n_fail++; end
        bus_idle();
        #2;
        rst2_n = 1'b0;  // between clock edges
        #1;
        n_checks++; if (d2_mc !== 2'd0 || d2_done !== 1'b0 || d2_fc !== 2'b00) begin $display("FAIL midrst_async got mc=%0d done=%b fc=%b expected 0 0 00", d2_mc, d2_done, d2_fc); n_fail++; end
        @(negedge clk); rst2_n = 1'b1;
        drive(2'b11, 32'd80, 32'hFFFF_FFFF);
        drive(2'b10, 32'd84, 32'h0000_1234);
        n_checks++; if (d2_pass !== 1'b1 || d2_mc !== 2'd2) begin $display("FAIL midrst_replay got pass=%b mc=%0d expected 1 2", d2_pass, d2_mc); n_fail++; end
        bus_idle();
        rst2_n = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk); rst2_n = 1'b1;
        // Second store fails on entry 1 by address; both cycles evaluated.
        drive(2'b11, 32'd80, 32'hFFFF_FFFF);
        n_checks++; if (d2_mc !== 2'd1 || d2_done !== 1'b0) begin $display("FAIL b2b_first got mc=%0d done=%b expected 1 0", d2_mc, d2_done); n_fail++; end
        drive(2'b11, 32'd80, 32'hFFFF_FFFF);
        n_checks++; if (d2_fc !== 2'b01 || d2_fidx !== 2'd1 || d2_mc !== 2'd1) begin $display("FAIL b2b_second got fc=%b fidx=%0d mc=%0d expected 01 1 1", d2_fc, d2_fidx, d2_mc); n_fail++; end
        drive(2'b10, 32'd84, 32'h0000_1234);
        n_checks++; if (d2_pass !== 1'b0 || d2_fc !== 2'b01) begin $display("FAIL b2b_hold got pass=%b fc=%b expected 0 01", d2_pass, d2_fc); n_fail++; end
        bus_idle();
        rst2_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_pass();
        test_byte_mask();
        test_addr_miss();
        test_data_nonstrict();
        test_strict();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_store_checker.md
# mips_store_checker

Parametrised, self-checking store-sequence monitor for the pipelined MIPS top-level bench. It watches the data-memory write port of `top`. It compares each store against an ordered list of NUM_EXP expected stores, each with an address, data and size. It reports pass, or the first failure with a cause code, and detects a hung program by timeout. It replaces the single-store, word-only, negedge checker used in each bench with one reusable, cycle-accurate block.

## Interface
Parameters:
- ADDR_W, 32, width of `dataadr`.
- DATA_W, 32, width of `writedata`; must be 32.
- NUM_EXP, 4, number of expected stores; must be at least 1.
- TIMEOUT, 4096, cycles from reset release to forced timeout fail; 0 disables the timeout.
- STRICT, 0, data-mismatch policy: 1 fails on a data/size mismatch; 0 ignores the store and keeps waiting.

Ports:
- clk, in, 1, sole clock; all sampling on the rising edge.
- reset_n, in, 1, asynchronous, active-low reset.
- memwrite, in, 2, store strobe/size: 00 none, 01 byte, 10 half, 11 word.
- dataadr, in, ADDR_W, store address.
- writedata, in, DATA_W, store data, right-aligned.
- exp_addr, in, NUM_EXP*ADDR_W, expected addresses; entry i is in slice i; quasi-static.
- exp_data, in, NUM_EXP*DATA_W, expected data; quasi-static.
- exp_size, in, NUM_EXP*2, expected size, same encoding as memwrite; must not be 00.
- done, out, 1, a terminal state has been reached.
- pass, out, 1, all NUM_EXP stores matched in order.
- fail_code, out, 2, 00 none, 01 address, 10 data/size, 11 timeout.
- fail_idx, out, clog2(NUM_EXP+1), index of the expected entry being waited on at failure.
- match_count, out, clog2(NUM_EXP+1), number of entries matched so far.

## Operation
- FSM states:
  - RUN is the state after reset.
  - PASS and FAIL are terminal; only reset exits them.
- In RUN, when memwrite != 00, compare against entry `idx` = match_count:
  - Address differs: go to FAIL with code 01. This holds in both modes.
  - Address equal, and size equal, and masked data equal: match_count increments. If the new match_count == NUM_EXP, go to PASS.
  - Data mask: byte compares [7:0], half compares [15:0], word compares [31:0]. Upper bits of writedata are ignored for byte and half.
  - Address equal but size or masked data differs:
    - STRICT=1: go to FAIL with code 10.
    - STRICT=0: no state change; the store is ignored.
- Timeout: a cycle counter runs in RUN only. When it reaches TIMEOUT-1 with no transition to PASS/FAIL on that edge, go to FAIL with code 11.
- Simultaneous events: a store evaluated on the same edge as the timeout takes priority. A completing match gives PASS; an address miss gives code 01.
- In PASS/FAIL, all inputs are ignored; outputs and the counter hold.
- Reset mid-operation: reset_n low asynchronously returns the block to the reset state, whatever the current state.

## Timing
- Reset values: state RUN, done 0, pass 0, fail_code 00, fail_idx 0, match_count 0, cycle counter 0.
- Latency: a store presented before rising edge N is reflected in match_count, done, pass and fail_* after edge N (1 cycle).
- All outputs are registered; there is no combinational path from inputs to outputs.
- fail_idx is captured on the failing edge and equals the match_count value before that edge.
- memwrite may be asserted back-to-back every cycle. Each asserted cycle is evaluated exactly once.

## Structure
- Package `mips_tb_pkg` holds:
  - enum `memwrite_t` {MW_NONE, MW_BYTE, MW_HALF, MW_WORD}
  - enum `chk_state_t` {RUN, PASS, FAIL}
  - enum `fail_code_t` {FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT}
  - function `size_mask(memwrite_t)`, which returns the 32-bit compare mask.
- One sub-module, `store_match`, is combinational. It takes one expected entry plus the live bus and produces `addr_hit` and `data_hit`.
- The top level of the block holds the FSM, the counters and the entry select (indexed part-select by match_count).

## Test plan
1. NUM_EXP=1, entry {80, 0xFFFFFFFF, word}; store 80/0xFFFFFFFF/11 at cycle 5 -> after that edge: pass=1, done=1, match_count=1, fail_code=00.
2. NUM_EXP=1, entry {80, 0x000000FF, byte}; store 80/0x123456FF/01 -> pass=1, because upper bytes are masked.
3. NUM_EXP=2, entries {80,…} and {84,…}; store 84 first -> FAIL, fail_code=01, fail_idx=0, match_count=0.
4. Entry {80, 0xFFFFFFFF, word}; store 80/0x00000000/11.
   - STRICT=1: fail_code=10.
   - STRICT=0: nothing changes; a following 80/0xFFFFFFFF/11 gives pass=1.
5. TIMEOUT=16, no stores -> fail_code=11 on the 16th edge after reset release. A matching store on that same edge gives pass=1 instead.
6. NUM_EXP=2; match entry 0, then pulse reset_n low mid-cycle -> outputs clear immediately. Replaying both stores then gives pass=1, match_count=2.
